// File: rtl/mantissa_div_if.sv
// Operand/result handshake bundle for the sequential mantissa divider.
interface mantissa_div_if #(parameter int MANTISSA_WIDTH = 15);
  logic                      in_valid;
  logic                      in_ready;
  logic [MANTISSA_WIDTH-1:0] Mantissa_X;
  logic [MANTISSA_WIDTH-1:0] Mantissa_Y;
  logic                      out_valid;
  logic                      out_ready;
  logic [MANTISSA_WIDTH-1:0] Mantissa_Out;
  logic                      Shift;
  logic                      Exact;

  modport master (
    output in_valid, Mantissa_X, Mantissa_Y, out_ready,
    input  in_ready, out_valid, Mantissa_Out, Shift, Exact
  );

  modport slave (
    input  in_valid, Mantissa_X, Mantissa_Y, out_ready,
    output in_ready, out_valid, Mantissa_Out, Shift, Exact
  );
endinterface

// File: rtl/mantissa_div_seq.sv
// Restoring divider for hidden-one mantissas: one quotient bit per cycle,
// normalized truncated quotient fraction plus exponent-adjust and exact flags.
module mantissa_div_seq #(
    parameter int MANTISSA_WIDTH = 15
) (
    input  logic               clk,
    input  logic               rst,
    mantissa_div_if.slave      io
);
    localparam int W  = MANTISSA_WIDTH;
    localparam int CW = $clog2(W + 2);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [W+1:0]    r_q, r_d;
    logic [W:0]      b_q, b_d;
    logic [W+1:0]    q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mant_q, mant_d;
    logic            shift_q, shift_d;
    logic            exact_q, exact_d;

    logic            r_ge;
    logic [W+1:0]    r_rem;
    logic [W+1:0]    r_step;
    logic [W+1:0]    q_step;

    // R < 2B holds throughout, so W+2 bits never overflow on the left shift.
    always_comb begin
        r_ge   = r_q >= {1'b0, b_q};
        r_rem  = r_ge ? (r_q - {1'b0, b_q}) : r_q;
        r_step = r_rem << 1;
        q_step = (q_q << 1) | {{(W+1){1'b0}}, r_ge};
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        b_d     = b_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mant_d  = mant_q;
        shift_d = shift_q;
        exact_d = exact_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    r_d     = {2'b01, io.Mantissa_X};
                    b_d     = {1'b1, io.Mantissa_Y};
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W + 1)) begin
                    // Quotient in (0.5, 2): drop the leading one from bit W+1 or W.
                    if (q_step[W+1]) begin
                        mant_d  = q_step[W:1];
                        shift_d = 1'b0;
                    end else begin
                        mant_d  = q_step[W-1:0];
                        shift_d = 1'b1;
                    end
                    exact_d = (r_step == '0) && (!q_step[W+1] || !q_step[0]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            mant_q  <= '0;
            shift_q <= 1'b0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            b_q     <= b_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mant_q  <= mant_d;
            shift_q <= shift_d;
            exact_q <= exact_d;
        end
    end

    assign io.in_ready     = (state_q == IDLE);
    assign io.out_valid    = (state_q == DONE);
    assign io.Mantissa_Out = mant_q;
    assign io.Shift        = shift_q;
    assign io.Exact        = exact_q;
endmodule
